tape_pulse_player: RTL
======================

TAPE_PULSE_PLAYER -- requirements
Module: tape_pulse_player

Interface
REQ-001 SHALL have parameter DEPTH, default 8, pulse FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter PW, default 16, pulse-length width in bits.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ce_1m, input, 1, one-clk-wide 1 MHz timebase tick.
REQ-006 SHALL have port motor, input, 1, tape motor enable from PPI port C bit 4.
REQ-007 SHALL have port flush, input, 1, one-clk request to discard all queued pulses.
REQ-008 SHALL have ports pulse_len (input, PW, pulse duration in µs ticks), pulse_valid (input, 1) and pulse_ready (output, 1).
REQ-009 SHALL have port tape_in, output, 1, cassette level to PPI port B bit 7.
REQ-010 SHALL have ports playing (output, 1, state is PLAY), underrun (output, 1, sticky starvation flag) and fifo_count (output, log2(DEPTH)+1, entries queued).

Function
REQ-011 SHALL accept a pulse on a clk edge with pulse_valid & pulse_ready; pulse_ready = (fifo_count < DEPTH) & ~flush, from registered count only (no same-cycle pop credit when full).
REQ-012 SHALL implement states IDLE, PLAY, STARVE.
REQ-013 IDLE -> PLAY when motor=1 and FIFO non-empty: pop head, load counter with head value (0 loaded as 1), tape_in unchanged.
REQ-014 In PLAY, counter SHALL decrement only on clk with ce_1m=1 and motor=1; motor=0 freezes counter and tape_in.
REQ-015 On a decrement tick with counter=1: tape_in SHALL toggle on that same edge; if FIFO non-empty, pop and reload (0 -> 1) on that edge, remaining PLAY; else enter STARVE and set underrun.
REQ-016 A pulse of length N (N>=1) SHALL hold tape_in stable for exactly N motor-enabled ce_1m ticks.
REQ-017 STARVE -> PLAY when FIFO non-empty and motor=1: pop and load, no toggle; tape_in held throughout STARVE.
REQ-018 underrun SHALL remain 1 until flush or reset.
REQ-019 Simultaneous push and pop in one cycle SHALL leave fifo_count unchanged and preserve order; push into empty FIFO is poppable the following cycle.
REQ-020 flush SHALL, on its edge, empty FIFO, zero counter, force IDLE, clear underrun, set tape_in=0, and ignore any same-cycle push.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; no overwrite when full, no pop when empty.

Reset
REQ-022 On reset: tape_in=0, playing=0, underrun=0, fifo_count=0, pulse_ready=0 during reset then 1, state IDLE, counter 0; reset mid-pulse SHALL discard the pulse and all queued entries.

Structure
REQ-023 Shared package tape_pkg SHALL hold state enum (IDLE, PLAY, STARVE) and default constants DEPTH=8, PW=16.
REQ-024 FIFO SHALL be the sub-module tape_pulse_fifo (push/pop/count, registered outputs); control FSM and counter in top.

Verification
REQ-025 Push 3, 5, 2 with motor=1, ce_1m every 16 clk -> tape_in toggles after 3, 8, 10 ticks from first load; then STARVE, underrun=1, tape_in held at 1.
REQ-026 Push 6, run 2 ticks, motor=0 for 50 ticks, motor=1 -> toggle after exactly 4 further ticks.
REQ-027 Fill 8 entries, motor=0 -> pulse_ready=0, fifo_count=8; 9th valid not accepted; motor=1 -> entries popped in push order.
REQ-028 Push length 0 -> tape_in toggles after 1 tick.
REQ-029 Mid-pulse with 4 queued, assert flush with pulse_valid=1 -> fifo_count=0, IDLE, tape_in=0, underrun=0, pushed value discarded.
REQ-030 Reset asserted in PLAY with 5 queued -> all outputs at REQ-022 values next cycle; new push after reset plays normally.

Source files
------------

// File: rtl/tape_pkg.sv
// Shared types and defaults for the cassette tape pulse player.
//   tape_state_e  : player control states
//   DEFAULT_DEPTH : default pulse FIFO depth (entries)
//   DEFAULT_PW    : default pulse-length width (bits)
package tape_pkg;

    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned DEFAULT_PW    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        STARVE = 2'd2
    } tape_state_e;

endpackage

// File: rtl/tape_pulse_fifo.sv
// Pulse-length FIFO for the tape player.
//   clk, reset : system clock, synchronous active-high reset
//   clr        : discard all entries (wins over push/pop)
//   push/push_data : write one entry when not full
//   pop        : drop the head entry when not empty
//   head       : entry at the read pointer
//   count      : entries queued (registered)
//   empty/full : registered status flags derived from the next count
module tape_pulse_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic [PW-1:0]            push_data,
    input  logic                     pop,
    output logic [PW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_n;

    // Guarded push/pop and next occupancy; simultaneous push+pop keeps count.
    always_comb begin
        do_push = push && !full && !clr;
        do_pop  = pop && !empty && !clr;
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
        if (clr) begin
            count_n = '0;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == CW'(DEPTH));
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/tape_pulse_player.sv
// Cassette tape pulse player: replays queued pulse lengths (in 1 MHz ticks)
// as level toggles on the cassette input line.
//   clk, reset   : system clock, synchronous active-high reset
//   ce_1m        : one-clk 1 MHz tick
//   motor        : tape motor enable; 0 freezes playback
//   flush        : discard queued pulses and return to idle
//   pulse_len/pulse_valid/pulse_ready : pulse push handshake
//   tape_in      : cassette level
//   playing      : controller is in PLAY
//   underrun     : sticky flag, FIFO ran dry at the end of a pulse
//   fifo_count   : entries queued
module tape_pulse_player
    import tape_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned PW    = DEFAULT_PW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce_1m,
    input  logic                     motor,
    input  logic                     flush,
    input  logic [PW-1:0]            pulse_len,
    input  logic                     pulse_valid,
    output logic                     pulse_ready,
    output logic                     tape_in,
    output logic                     playing,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    tape_state_e   state;
    tape_state_e   state_n;
    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_n;
    logic          tape_n;
    logic          underrun_n;
    logic          fifo_pop;
    logic          fifo_push;
    logic [PW-1:0] fifo_head;
    logic          fifo_empty;
    logic          fifo_full;
    logic [PW-1:0] load_val;
    logic          tick;

    // Ready comes from registered occupancy only; a pop this cycle gives no credit.
    assign pulse_ready = !reset && !flush && !fifo_full;
    assign fifo_push   = pulse_valid && pulse_ready;

    // A zero-length pulse is played as one tick.
    assign load_val = (fifo_head == '0) ? PW'(1) : fifo_head;
    assign tick     = ce_1m && motor;

    tape_pulse_fifo #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (flush),
        .push      (fifo_push),
        .push_data (pulse_len),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            tape_in  <= 1'b0;
            underrun <= 1'b0;
            playing  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            tape_in  <= tape_n;
            underrun <= underrun_n;
            playing  <= (state_n == PLAY);
        end
    end

    // Next-state, counter and level logic.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        tape_n     = tape_in;
        underrun_n = underrun;
        fifo_pop   = 1'b0;

        case (state)
            IDLE, STARVE: begin
                // Loading a pulse never toggles the level.
                if (motor && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    cnt_n    = load_val;
                    state_n  = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (cnt <= PW'(1)) begin
                        // Pulse ends: toggle and chain the next pulse on the same edge.
                        tape_n = !tape_in;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            cnt_n    = load_val;
                        end else begin
                            cnt_n      = '0;
                            state_n    = STARVE;
                            underrun_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt - PW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        if (flush) begin
            state_n    = IDLE;
            cnt_n      = '0;
            tape_n     = 1'b0;
            underrun_n = 1'b0;
            fifo_pop   = 1'b0;
        end
    end

endmodule
